// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the two-master SRAM-like request arbiter:
// owner encodings stored in the in-flight FIFO and SRAM-like size codes.
package sram_req_arbiter_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } sram_size_e;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// In-order owner FIFO: one bit per in-flight transaction telling which
// master issued it, so responses can be steered back in issue order.
module sram_req_arbiter_owner_fifo #(
    parameter int OUTSTANDING = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = PW + 1;

    logic [OUTSTANDING-1:0] mem_q, mem_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   do_push, do_pop;

    assign full  = (count_q == CW'(OUTSTANDING));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A push while full is only taken when a pop frees the slot in the same cycle.
    always_comb begin
        do_push  = push & (~full | pop);
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_owner;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Merges the CPU inst and data SRAM-like ports onto one downstream port:
// data-priority arbitration with inst anti-starvation, sticky grant, in-order response steering.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic        i_cached,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_cached,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        s_req,
    output logic        s_cached,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    output logic        busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          lock_q, lock_d;
    logic          lock_owner_q, lock_owner_d;
    logic [SW-1:0] starve_q, starve_d;

    logic sel_valid, sel, sel_req, hs;
    logic fifo_full, fifo_empty, fifo_head, fifo_pop;

    // Grant selection: a held lock overrides priority until the address handshake.
    always_comb begin
        sel_valid = 1'b0;
        sel       = OWNER_INST;
        if (lock_q) begin
            sel_valid = 1'b1;
            sel       = lock_owner_q;
        end else if (d_req && !(i_req && starve_q == SW'(STARVE_LIMIT))) begin
            sel_valid = 1'b1;
            sel       = OWNER_DATA;
        end else if (i_req) begin
            sel_valid = 1'b1;
            sel       = OWNER_INST;
        end
        sel_req = sel_valid & ((sel == OWNER_DATA) ? d_req : i_req);
    end

    // Outputs are forced low while reset is asserted, even with requests pending.
    assign s_req = resetn & sel_req & ~fifo_full;
    assign hs    = s_req & s_addr_ok;

    always_comb begin
        s_cached = 1'b0;
        s_wr     = 1'b0;
        s_size   = 2'b00;
        s_wstrb  = 4'h0;
        s_addr   = 32'h0;
        s_wdata  = 32'h0;
        if (resetn && sel_valid) begin
            if (sel == OWNER_DATA) begin
                s_cached = d_cached;
                s_wr     = d_wr;
                s_size   = d_size;
                s_wstrb  = d_wstrb;
                s_addr   = d_addr;
                s_wdata  = d_wdata;
            end else begin
                s_cached = i_cached;
                s_wr     = i_wr;
                s_size   = i_size;
                s_wstrb  = i_wstrb;
                s_addr   = i_addr;
                s_wdata  = i_wdata;
            end
        end
    end

    assign i_addr_ok = hs & (sel == OWNER_INST);
    assign d_addr_ok = hs & (sel == OWNER_DATA);

    // A held lock survives a full FIFO; it drops on handshake or when its master withdraws.
    always_comb begin
        lock_owner_d = lock_q ? lock_owner_q : sel;
        lock_d       = lock_q ? (sel_req & ~hs) : (s_req & ~s_addr_ok);

        starve_d = starve_q;
        if (!i_req || i_addr_ok) begin
            starve_d = '0;
        end else if (d_addr_ok && starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INST;
            starve_q     <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            starve_q     <= starve_d;
        end
    end

    assign fifo_pop = resetn & s_data_ok & ~fifo_empty;

    sram_req_arbiter_owner_fifo #(
        .OUTSTANDING(OUTSTANDING)
    ) u_owner_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (hs),
        .push_owner(sel),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign i_data_ok = fifo_pop & (fifo_head == OWNER_INST);
    assign d_data_ok = fifo_pop & (fifo_head == OWNER_DATA);
    assign i_rdata   = i_data_ok ? s_rdata : 32'h0;
    assign d_rdata   = d_data_ok ? s_rdata : 32'h0;
    assign busy      = ~fifo_empty;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: each vector's expected outputs are hand-derived.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, i_cached, i_wr;
    logic [1:0]  i_size;
    logic [3:0]  i_wstrb;
    logic [31:0] i_addr, i_wdata;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_cached, d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        s_req, s_cached, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_cached(i_cached), .i_wr(i_wr), .i_size(i_size),
        .i_wstrb(i_wstrb), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_cached(d_cached), .d_wr(d_wr), .d_size(d_size),
        .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .s_req(s_req), .s_cached(s_cached), .s_wr(s_wr), .s_size(s_size),
        .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        i_req = 0; i_cached = 0; i_wr = 0; i_size = 2'd2; i_wstrb = 4'hF;
        i_addr = 0; i_wdata = 0;
        d_req = 0; d_cached = 0; d_wr = 0; d_size = 2'd0; d_wstrb = 4'h0;
        d_addr = 0; d_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;

        // Reset state, with a request pending to show outputs stay low
        i_req = 1; s_addr_ok = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_req", 32'(s_req), 0);
        chk("rst_i_addr_ok", 32'(i_addr_ok), 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_busy", 32'(busy), 0);
        i_req = 0; s_addr_ok = 0;
        resetn = 1'b1;
        next_cycle();

        // Single inst fetch with zero-latency address phase
        i_req = 1; i_addr = 32'hBFC00000; s_addr_ok = 1;
        settle();
        chk("t1_s_req", 32'(s_req), 1);
        chk("t1_s_addr", s_addr, 32'hBFC00000);
        chk("t1_i_addr_ok", 32'(i_addr_ok), 1);
        chk("t1_d_addr_ok", 32'(d_addr_ok), 0);
        next_cycle();
        i_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h3C080001;
        settle();
        chk("t1_i_data_ok", 32'(i_data_ok), 1);
        chk("t1_i_rdata", i_rdata, 32'h3C080001);
        chk("t1_d_data_ok", 32'(d_data_ok), 0);
        chk("t1_busy_pre", 32'(busy), 1);
        next_cycle();
        s_data_ok = 0;
        settle();
        chk("t1_busy_post", 32'(busy), 0);

        // Simultaneous requests: data first, then inst; responses in order
        i_req = 1; d_req = 1; i_addr = 32'h0000_1000; d_addr = 32'h8000_0040;
        d_size = 2'd1; d_wstrb = 4'h3; s_addr_ok = 1;
        settle();
        chk("t2_s_addr_d", s_addr, 32'h8000_0040);
        chk("t2_s_size_d", 32'(s_size), 1);
        chk("t2_s_wstrb_d", 32'(s_wstrb), 32'h3);
        chk("t2_d_addr_ok", 32'(d_addr_ok), 1);
        chk("t2_i_addr_ok0", 32'(i_addr_ok), 0);
        next_cycle();
        d_req = 0;
        settle();
        chk("t2_s_addr_i", s_addr, 32'h0000_1000);
        chk("t2_i_addr_ok1", 32'(i_addr_ok), 1);
        next_cycle();
        i_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h1111_1111;
        settle();
        chk("t2_r1_d_data_ok", 32'(d_data_ok), 1);
        chk("t2_r1_d_rdata", d_rdata, 32'h1111_1111);
        chk("t2_r1_i_data_ok", 32'(i_data_ok), 0);
        chk("t2_r1_i_rdata", i_rdata, 0);
        next_cycle();
        s_rdata = 32'h2222_2222;
        settle();
        chk("t2_r2_i_data_ok", 32'(i_data_ok), 1);
        chk("t2_r2_i_rdata", i_rdata, 32'h2222_2222);
        chk("t2_r2_d_data_ok", 32'(d_data_ok), 0);
        next_cycle();
        s_data_ok = 0;
        settle();
        chk("t2_busy", 32'(busy), 0);

        // Sticky grant across a stalled address phase
        i_req = 1; i_addr = 32'hA000_0300; s_addr_ok = 0;
        settle();
        chk("t3_c1_s_addr", s_addr, 32'hA000_0300);
        chk("t3_c1_i_addr_ok", 32'(i_addr_ok), 0);
        next_cycle();
        d_req = 1; d_addr = 32'hD000_0300;
        settle();
        chk("t3_c2_s_addr", s_addr, 32'hA000_0300);
        chk("t3_c2_d_addr_ok", 32'(d_addr_ok), 0);
        next_cycle();
        settle();
        chk("t3_c3_s_addr", s_addr, 32'hA000_0300);
        next_cycle();
        s_addr_ok = 1;
        settle();
        chk("t3_hs_s_addr", s_addr, 32'hA000_0300);
        chk("t3_hs_i_addr_ok", 32'(i_addr_ok), 1);
        chk("t3_hs_d_addr_ok", 32'(d_addr_ok), 0);
        next_cycle();
        i_req = 0;
        settle();
        chk("t3_d_s_addr", s_addr, 32'hD000_0300);
        chk("t3_d_addr_ok", 32'(d_addr_ok), 1);
        next_cycle();
        d_req = 0; s_addr_ok = 0; s_data_ok = 1;
        settle();
        chk("t3_rsp1_i", 32'(i_data_ok), 1);
        next_cycle();
        settle();
        chk("t3_rsp2_d", 32'(d_data_ok), 1);
        next_cycle();
        s_data_ok = 0;

        // Anti-starvation: 4 data grants then 1 inst grant, repeating
        i_req = 1; d_req = 1; s_addr_ok = 1;
        for (int k = 0; k < 10; k++) begin
            s_data_ok = (k > 0);
            settle();
            chk($sformatf("t4_d_grant_%0d", k), 32'(d_addr_ok), (k % 5 == 4) ? 0 : 1);
            chk($sformatf("t4_i_grant_%0d", k), 32'(i_addr_ok), (k % 5 == 4) ? 1 : 0);
            if (k > 0)
                chk($sformatf("t4_i_rsp_%0d", k), 32'(i_data_ok), ((k - 1) % 5 == 4) ? 1 : 0);
            next_cycle();
        end
        i_req = 0; d_req = 0; s_addr_ok = 0; s_data_ok = 1;
        settle();
        chk("t4_last_rsp_i", 32'(i_data_ok), 1);
        next_cycle();
        s_data_ok = 0;
        settle();
        chk("t4_busy", 32'(busy), 0);

        // Fill the owner FIFO (I,D,I,D) across the pointer wrap
        s_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            i_req = (k % 2 == 0);
            d_req = (k % 2 == 1);
            settle();
            chk($sformatf("t5_fill_hs_%0d", k), 32'(s_req), 1);
            next_cycle();
        end
        i_req = 0; d_req = 1; d_addr = 32'hD000_0500;
        settle();
        chk("t5_full_s_req", 32'(s_req), 0);
        chk("t5_full_d_addr_ok", 32'(d_addr_ok), 0);
        chk("t5_full_busy", 32'(busy), 1);
        next_cycle();
        s_data_ok = 1; s_rdata = 32'h5555_0001;
        settle();
        chk("t5_full_pop_s_req", 32'(s_req), 0);
        chk("t5_pop1_i_data_ok", 32'(i_data_ok), 1);
        chk("t5_pop1_i_rdata", i_rdata, 32'h5555_0001);
        next_cycle();
        s_rdata = 32'h5555_0002;
        settle();
        chk("t5_pushpop_d_addr_ok", 32'(d_addr_ok), 1);
        chk("t5_pop2_d_data_ok", 32'(d_data_ok), 1);
        chk("t5_pop2_d_rdata", d_rdata, 32'h5555_0002);
        next_cycle();
        d_req = 0; s_addr_ok = 0;
        settle();
        chk("t5_pop3_i_data_ok", 32'(i_data_ok), 1);
        next_cycle();
        settle();
        chk("t5_pop4_d_data_ok", 32'(d_data_ok), 1);
        chk("t5_pop4_busy", 32'(busy), 1);
        next_cycle();
        settle();
        chk("t5_pop5_d_data_ok", 32'(d_data_ok), 1);
        next_cycle();
        s_data_ok = 0;
        settle();
        chk("t5_busy", 32'(busy), 0);

        // Reset mid-flight with 2 outstanding
        i_req = 1; d_req = 1; s_addr_ok = 1;
        next_cycle();
        next_cycle();
        s_data_ok = 1;
        resetn = 1'b0;
        settle();
        chk("t6_rst_s_req", 32'(s_req), 0);
        chk("t6_rst_addr_ok", 32'({i_addr_ok, d_addr_ok}), 0);
        chk("t6_rst_data_ok", 32'({i_data_ok, d_data_ok}), 0);
        chk("t6_rst_s_addr", s_addr, 0);
        chk("t6_rst_busy", 32'(busy), 0);
        next_cycle();
        i_req = 0; d_req = 0; s_addr_ok = 0;
        resetn = 1'b1;
        settle();
        chk("t6_post_i_data_ok", 32'(i_data_ok), 0);
        chk("t6_post_d_data_ok", 32'(d_data_ok), 0);
        chk("t6_post_busy", 32'(busy), 0);
        next_cycle();
        s_data_ok = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
